z80_sysctrl: RTL and testbench

//  Parametrised Z80 system-control slave: N input ports, a bank of write-only control latches, a vblank NMI generator,
//  a maskable edge IRQ with INTA clear, and a windowed wait-state generator with timeout.

---
 rtl/z80_sysctrl_pkg.sv | 40 ++++
 rtl/z80_sysctrl_debounce.sv | 60 ++++++
 rtl/z80_sysctrl.sv | 144 ++++++++++++++
 tb/tb_z80_sysctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/z80_sysctrl_pkg.sv
// Shared types and helpers for the Z80 system-control slave: bus structs,
// latch bit names, wait counter type and the address-decode helper.
package z80_sysctrl_pkg;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dmaster;
    logic        rdn;
    logic        wrn;
    logic        inta;
  } z80_master_bus_t;

  typedef struct packed {
    logic [7:0] dslave;
    logic       mwait;
  } z80_slave_bus_t;

  typedef enum int {
    AUDIO_IRQ = 0,
    GRID      = 1,
    FLIP      = 2,
    PSL2      = 3,
    NMI_MASK  = 4,
    DMA_RDY   = 5,
    CREF0     = 6,
    CREF1     = 7
  } latch_idx_e;

  typedef logic [7:0] wait_cnt_t;

  function automatic logic addr_match(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input logic [15:0] stride,
                                      input int unsigned idx);
    logic [15:0] off;
    off = 16'(idx) * stride;
    return addr == (base + off);
  endfunction

endpackage

// File: rtl/z80_sysctrl_debounce.sv
// Per-bit input conditioner: 2-flop synchroniser, plus a stability filter
// when SYSCTRL_DEBOUNCE_EN is defined.
module z80_debounce
`ifdef SYSCTRL_DEBOUNCE_EN
  #(parameter int DEB_CYC = 1024)
`endif
  (
  input  logic masterclk,
  input  logic rst,
  input  logic raw_i,
  output logic filt_o
);

  logic sync1_q, sync2_q;

  always_ff @(posedge masterclk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef SYSCTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYC) + 1;

  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A differing sample must persist DEB_CYC cycles before it is accepted.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(DEB_CYC - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge masterclk) begin
    if (rst) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;
`else
  assign filt_o = sync2_q;
`endif

endmodule

// File: rtl/z80_sysctrl.sv
// Z80 system-control slave: input ports, write-only control latches, vblank NMI,
// edge IRQ with INTA clear, windowed wait generator. Option: SYSCTRL_DEBOUNCE_EN.
module z80_sysctrl
  import z80_sysctrl_pkg::*;
#(
  parameter int          NUM_IN       = 4,
  parameter logic [15:0] IN_BASE      = 16'h7C00,
  parameter logic [15:0] IN_STRIDE    = 16'h0080,
  parameter int          NUM_LATCH    = 8,
  parameter logic [15:0] LATCH_BASE   = 16'h7D80,
  parameter logic [15:0] LATCH_RST    = 16'h0007,
  parameter int          NMI_MASK_BIT = NMI_MASK,
  parameter logic [15:0] WAIT_LO      = 16'h7400,
  parameter logic [15:0] WAIT_HI      = 16'h77FF,
  parameter int          WAIT_MAX     = 255
`ifdef SYSCTRL_DEBOUNCE_EN
  , parameter int        DEB_CYC      = 1024
`endif
) (
  input  logic                  masterclk,
  input  logic                  rst,
  input  logic                  ena,
  input  z80_master_bus_t       ibus,
  output z80_slave_bus_t        obus,
  input  logic                  cpuclk,
  input  logic                  vblk,
  input  logic                  win_busy,
  input  logic                  irq_src,
  input  logic [NUM_IN*8-1:0]   in_ports,
  output logic [NUM_LATCH-1:0]  latch_q,
  output logic                  nmi_n,
  output logic                  int_n,
  output logic                  cpu_wait_n,
  output logic                  wait_tmo
);

  logic [NUM_IN*8-1:0] filt;

  for (genvar b = 0; b < NUM_IN*8; b++) begin : g_deb
    z80_debounce
`ifdef SYSCTRL_DEBOUNCE_EN
      #(.DEB_CYC(DEB_CYC))
`endif
      u_deb (
        .masterclk(masterclk),
        .rst      (rst),
        .raw_i    (in_ports[b]),
        .filt_o   (filt[b])
      );
  end

  logic [NUM_LATCH-1:0] latch_d;
  logic [7:0]           dslave_q, dslave_d, rd_data;
  logic                 nmi_q, nmi_d, int_q, int_d;
  logic                 wait_q, wait_d, tmo_q, tmo_d;
  wait_cnt_t            cnt_q, cnt_d;
  logic                 vblk_q, irq_q, cpuclk_q;
  logic                 req;
  logic                 unused_dmaster;

  assign unused_dmaster = ^ibus.dmaster[7:1];
  assign req = (ibus.addr >= WAIT_LO) && (ibus.addr <= WAIT_HI) && win_busy;

  always_comb begin
    rd_data = 8'hFF;
    for (int k = 0; k < NUM_IN; k++) begin
      if (addr_match(ibus.addr, IN_BASE, IN_STRIDE, k)) rd_data = filt[8*k +: 8];
    end

    dslave_d = dslave_q;
    if (ena && !ibus.rdn) dslave_d = rd_data;

    latch_d = latch_q;
    if (ena && !ibus.wrn) begin
      for (int j = 0; j < NUM_LATCH; j++) begin
        if (addr_match(ibus.addr, LATCH_BASE, 16'd1, j)) latch_d[j] = ibus.dmaster[0];
      end
    end

    // Mask is taken from the post-write value so a coincident clear wins.
    nmi_d = nmi_q;
    if (!latch_d[NMI_MASK_BIT])  nmi_d = 1'b1;
    else if (vblk && !vblk_q)    nmi_d = 1'b0;

    int_d = int_q;
    if (irq_src && !irq_q)       int_d = 1'b0;
    else if (ibus.inta)          int_d = 1'b1;

    wait_d = wait_q;
    cnt_d  = cnt_q;
    tmo_d  = tmo_q;
    if (vblk) begin
      wait_d = 1'b1;
      cnt_d  = '0;
    end else if (!cpuclk && cpuclk_q) begin
      if (!req) begin
        wait_d = 1'b1;
        cnt_d  = '0;
      end else if (cnt_q == wait_cnt_t'(WAIT_MAX)) begin
        wait_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == wait_cnt_t'(WAIT_MAX)) begin
          wait_d = 1'b1;
          tmo_d  = 1'b1;
        end else begin
          wait_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge masterclk) begin
    if (rst) begin
      latch_q  <= LATCH_RST[NUM_LATCH-1:0];
      dslave_q <= 8'hFF;
      nmi_q    <= 1'b1;
      int_q    <= 1'b1;
      wait_q   <= 1'b1;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      latch_q  <= latch_d;
      dslave_q <= dslave_d;
      nmi_q    <= nmi_d;
      int_q    <= int_d;
      wait_q   <= wait_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
    // Edge detectors always track the live level, so reset release sees no edge.
    vblk_q   <= vblk;
    irq_q    <= irq_src;
    cpuclk_q <= cpuclk;
  end

  assign obus.dslave = dslave_q;
  assign obus.mwait  = wait_q;
  assign nmi_n       = nmi_q;
  assign int_n       = int_q;
  assign cpu_wait_n  = wait_q;
  assign wait_tmo    = tmo_q;

endmodule

// File: tb/tb_z80_sysctrl.sv
// Directed self-checking bench for z80_sysctrl (WAIT_MAX overridden to 3).
module tb_z80_sysctrl;
  import z80_sysctrl_pkg::*;

  logic            masterclk = 1'b0;
  logic            rst, ena, cpuclk, vblk, win_busy, irq_src;
  z80_master_bus_t ibus;
  z80_slave_bus_t  obus;
  logic [31:0]     in_ports;
  logic [7:0]      latch_q;
  logic            nmi_n, int_n, cpu_wait_n, wait_tmo;

  int n_pass  = 0;
  int n_total = 0;

`ifdef SYSCTRL_DEBOUNCE_EN
  localparam int SETTLE = 1024 + 8;
`else
  localparam int SETTLE = 4;
`endif

  z80_sysctrl #(.WAIT_MAX(3)) dut (
    .masterclk (masterclk),
    .rst       (rst),
    .ena       (ena),
    .ibus      (ibus),
    .obus      (obus),
    .cpuclk    (cpuclk),
    .vblk      (vblk),
    .win_busy  (win_busy),
    .irq_src   (irq_src),
    .in_ports  (in_ports),
    .latch_q   (latch_q),
    .nmi_n     (nmi_n),
    .int_n     (int_n),
    .cpu_wait_n(cpu_wait_n),
    .wait_tmo  (wait_tmo)
  );

  always #5 masterclk = ~masterclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge masterclk);
    #1;
  endtask

  task automatic wr_latch(input logic [15:0] a, input logic [7:0] d);
    ena = 1'b1; ibus.wrn = 1'b0; ibus.addr = a; ibus.dmaster = d;
    tick();
    ena = 1'b0; ibus.wrn = 1'b1;
  endtask

  task automatic rd_port(input logic [15:0] a);
    ena = 1'b1; ibus.rdn = 1'b0; ibus.addr = a;
    tick();
    ena = 1'b0; ibus.rdn = 1'b1;
  endtask

  task automatic cpu_fall();
    cpuclk = 1'b1; tick();
    cpuclk = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_total++; if (latch_q !== 8'h07) $display("FAIL rst_latch got %h exp 07", latch_q); else n_pass++;
    n_total++; if ({nmi_n, int_n, cpu_wait_n, wait_tmo} !== 4'b1110)
      $display("FAIL rst_flags got %b exp 1110", {nmi_n, int_n, cpu_wait_n, wait_tmo}); else n_pass++;
    n_total++; if (obus !== {8'hFF, 1'b1}) $display("FAIL rst_obus got %h exp 1ff", obus); else n_pass++;
    rst = 1'b0; tick();
  endtask

  task automatic test_read();
    in_ports = 32'h11A52233;
    repeat (SETTLE) tick();
    ena = 1'b1; ibus.rdn = 1'b0; ibus.addr = 16'h7D00;
    #1;
    n_total++; if (obus.dslave !== 8'hFF) $display("FAIL rd_latency got %h exp ff", obus.dslave); else n_pass++;
    tick(); ena = 1'b0; ibus.rdn = 1'b1;
    n_total++; if (obus.dslave !== 8'hA5) $display("FAIL rd_port2 got %h exp a5", obus.dslave); else n_pass++;
    rd_port(16'h7C00);
    n_total++; if (obus.dslave !== 8'h33) $display("FAIL rd_port0 got %h exp 33", obus.dslave); else n_pass++;
    rd_port(16'h7D80);
    n_total++; if (obus.dslave !== 8'h11) $display("FAIL rd_port3 got %h exp 11", obus.dslave); else n_pass++;
    rd_port(16'h7C40);
    n_total++; if (obus.dslave !== 8'hFF) $display("FAIL rd_unmapped got %h exp ff", obus.dslave); else n_pass++;
    rd_port(16'h7C80);
    ibus.addr = 16'h7D00; ibus.rdn = 1'b0; tick(); ibus.rdn = 1'b1;
    n_total++; if (obus.dslave !== 8'h22) $display("FAIL rd_hold_noena got %h exp 22", obus.dslave); else n_pass++;
  endtask

  task automatic test_nmi();
    wr_latch(16'h7D84, 8'h01);
    n_total++; if (latch_q !== 8'h17) $display("FAIL nmi_masklatch got %h exp 17", latch_q); else n_pass++;
    vblk = 1'b1; tick();
    n_total++; if (nmi_n !== 1'b0) $display("FAIL nmi_assert got %b exp 0", nmi_n); else n_pass++;
    vblk = 1'b0; tick(); tick();
    n_total++; if (nmi_n !== 1'b0) $display("FAIL nmi_hold got %b exp 0", nmi_n); else n_pass++;
    wr_latch(16'h7D84, 8'h00);
    n_total++; if (nmi_n !== 1'b1) $display("FAIL nmi_release got %b exp 1", nmi_n); else n_pass++;
    wr_latch(16'h7D84, 8'h01);
    ena = 1'b1; ibus.wrn = 1'b0; ibus.addr = 16'h7D84; ibus.dmaster = 8'h00; vblk = 1'b1;
    tick();
    ena = 1'b0; ibus.wrn = 1'b1;
    n_total++; if (nmi_n !== 1'b1) $display("FAIL nmi_clear_wins got %b exp 1", nmi_n); else n_pass++;
    vblk = 1'b0; tick();
    wr_latch(16'h7D81, 8'hFE);
    wr_latch(16'h7D81, 8'hFE);
    wr_latch(16'h7D88, 8'h01);
    wr_latch(16'h7D87, 8'h03);
    n_total++; if (latch_q !== 8'h85) $display("FAIL latch_writes got %h exp 85", latch_q); else n_pass++;
  endtask

  task automatic test_int();
    irq_src = 1'b1; tick();
    n_total++; if (int_n !== 1'b0) $display("FAIL int_assert got %b exp 0", int_n); else n_pass++;
    tick();
    ibus.inta = 1'b1; tick(); ibus.inta = 1'b0;
    n_total++; if (int_n !== 1'b1) $display("FAIL int_inta_clear got %b exp 1", int_n); else n_pass++;
    tick();
    n_total++; if (int_n !== 1'b1) $display("FAIL int_level_no_edge got %b exp 1", int_n); else n_pass++;
    irq_src = 1'b0; tick();
    irq_src = 1'b1; ibus.inta = 1'b1; tick(); ibus.inta = 1'b0;
    n_total++; if (int_n !== 1'b0) $display("FAIL int_edge_wins got %b exp 0", int_n); else n_pass++;
    irq_src = 1'b0; ibus.inta = 1'b1; tick(); ibus.inta = 1'b0;
  endtask

  task automatic test_wait();
    ibus.addr = 16'h7500; win_busy = 1'b1; vblk = 1'b0;
    cpuclk = 1'b1; tick();
    n_total++; if (cpu_wait_n !== 1'b1) $display("FAIL wait_idle got %b exp 1", cpu_wait_n); else n_pass++;
    cpuclk = 1'b0; tick();
    n_total++; if (cpu_wait_n !== 1'b0 || obus.mwait !== 1'b0)
      $display("FAIL wait_assert got %b/%b exp 0/0", cpu_wait_n, obus.mwait); else n_pass++;
    win_busy = 1'b0; cpuclk = 1'b1; tick();
    n_total++; if (cpu_wait_n !== 1'b0) $display("FAIL wait_only_on_fall got %b exp 0", cpu_wait_n); else n_pass++;
    cpuclk = 1'b0; tick();
    n_total++; if (cpu_wait_n !== 1'b1) $display("FAIL wait_release got %b exp 1", cpu_wait_n); else n_pass++;
    win_busy = 1'b1; cpu_fall();
    vblk = 1'b1; tick();
    n_total++; if (cpu_wait_n !== 1'b1) $display("FAIL wait_vblk got %b exp 1", cpu_wait_n); else n_pass++;
    vblk = 1'b0;
    ibus.addr = 16'h7800; cpu_fall();
    n_total++; if (cpu_wait_n !== 1'b1) $display("FAIL wait_outside got %b exp 1", cpu_wait_n); else n_pass++;
    ibus.addr = 16'h77FF; cpu_fall();
    n_total++; if (cpu_wait_n !== 1'b0) $display("FAIL wait_hi_edge got %b exp 0", cpu_wait_n); else n_pass++;
    win_busy = 1'b0; cpu_fall();
    n_total++; if (wait_tmo !== 1'b0) $display("FAIL wait_no_tmo got %b exp 0", wait_tmo); else n_pass++;
  endtask

  task automatic test_timeout();
    ibus.addr = 16'h7400; win_busy = 1'b1;
    cpu_fall(); cpu_fall();
    n_total++; if ({cpu_wait_n, wait_tmo} !== 2'b00)
      $display("FAIL tmo_second_fall got %b exp 00", {cpu_wait_n, wait_tmo}); else n_pass++;
    cpu_fall();
    n_total++; if ({cpu_wait_n, wait_tmo} !== 2'b11)
      $display("FAIL tmo_third_fall got %b exp 11", {cpu_wait_n, wait_tmo}); else n_pass++;
    cpu_fall();
    n_total++; if ({cpu_wait_n, wait_tmo} !== 2'b11)
      $display("FAIL tmo_hold got %b exp 11", {cpu_wait_n, wait_tmo}); else n_pass++;
    win_busy = 1'b0; cpu_fall();
    win_busy = 1'b1; cpu_fall();
    n_total++; if ({cpu_wait_n, wait_tmo} !== 2'b01)
      $display("FAIL tmo_sticky_rewait got %b exp 01", {cpu_wait_n, wait_tmo}); else n_pass++;
  endtask

  task automatic test_reset_midwait();
    for (int j = 0; j < 8; j++) wr_latch(16'h7D80 + 16'(j), 8'h01);
    n_total++; if (latch_q !== 8'hFF) $display("FAIL mid_latch_ff got %h exp ff", latch_q); else n_pass++;
    vblk = 1'b1; tick(); vblk = 1'b0; tick();
    irq_src = 1'b1; tick();
    rd_port(16'h7D00);
    ibus.addr = 16'h7500; win_busy = 1'b1; cpu_fall();
    n_total++; if ({nmi_n, int_n, cpu_wait_n, obus.dslave} !== {3'b000, 8'hA5})
      $display("FAIL mid_pre_state got %b%b%b %h exp 000 a5", nmi_n, int_n, cpu_wait_n, obus.dslave); else n_pass++;
    vblk = 1'b1;
    rst = 1'b1; tick(); rst = 1'b0;
    n_total++; if (latch_q !== 8'h07) $display("FAIL mid_rst_latch got %h exp 07", latch_q); else n_pass++;
    n_total++; if ({nmi_n, int_n, cpu_wait_n, wait_tmo, obus.dslave} !== {4'b1110, 8'hFF})
      $display("FAIL mid_rst_out got %b %h exp 1110 ff", {nmi_n, int_n, cpu_wait_n, wait_tmo}, obus.dslave); else n_pass++;
    repeat (3) tick();
    n_total++; if ({nmi_n, int_n} !== 2'b11) $display("FAIL mid_no_spurious got %b exp 11", {nmi_n, int_n}); else n_pass++;
    vblk = 1'b0; irq_src = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ena = 1'b0; cpuclk = 1'b1; vblk = 1'b0; win_busy = 1'b0; irq_src = 1'b0;
    in_ports = 32'h0;
    ibus.addr = 16'h0000; ibus.dmaster = 8'h00; ibus.rdn = 1'b1; ibus.wrn = 1'b1; ibus.inta = 1'b0;
    test_reset();
    test_read();
    test_nmi();
    test_int();
    test_wait();
    test_timeout();
    test_reset_midwait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
